mem_responder: RTL

Word-organised data memory acting as the responder end of the multicycle core's load/store port. It accepts one request at a time from the control unit/datapath, applies configurable wait states, and performs lane-aligned byte, halfword and word writes. Store strobes from the core arrive lane-0 aligned (0001/0011/1111) and are shifted here by the address offset. Load data is extracted and sign- or zero-extended per funct3, and a one-cycle response pulse is returned.

---
 rtl/mem_responder_if.sv | 40 ++++
 rtl/mem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Load/store request-response bundle between the core and its data memory.
// The master side issues requests, the slave side returns one response pulse per request.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_wstrb,
    output req_funct3,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_wstrb,
    input  req_funct3,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised data memory with wait states, lane-aligned stores and
// sign/zero-extended loads; one request in flight, one-cycle response pulse.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  mem_responder_if.slave bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  funct3;
  } req_t;

  state_t      st, st_nx;
  logic [3:0]  cnt;
  req_t        r;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        access;
  logic [1:0]  off;
  logic [29:0] idx;
  logic        oob;
  logic        st_bad;
  logic        ld_bad;
  logic        err_c;
  logic [31:0] word;
  logic [31:0] w;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] wl;

  assign accept = bus.req_valid && bus.req_ready;
  assign access = (st == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (accept) st_nx = WAIT;
      WAIT:    if (cnt == 4'd0) st_nx = RESP;
      RESP:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (st == IDLE);
    bus.rsp_valid = (st == RESP);
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign off = r.addr[1:0];
  assign idx = r.addr[31:2];
  assign oob = {2'b00, idx} >= 32'(DEPTH_WORDS);

  always_comb begin
    st_bad = 1'b1;
    case (r.wstrb)
      4'b0001: st_bad = 1'b0;
      4'b0011: st_bad = off[0];
      4'b1111: st_bad = (off != 2'd0);
      default: st_bad = 1'b1;
    endcase
  end

  always_comb begin
    ld_bad = 1'b1;
    case (r.funct3)
      3'b000, 3'b100: ld_bad = 1'b0;
      3'b001, 3'b101: ld_bad = off[0];
      3'b010:         ld_bad = (off != 2'd0);
      default:        ld_bad = 1'b1;
    endcase
  end

  assign err_c = oob | (r.write ? st_bad : ld_bad);

  assign word = oob ? 32'd0 : mem[idx[AW-1:0]];
  assign w    = word >> {off, 3'b000};

  always_comb begin
    ld_data = w;
    case (r.funct3)
      3'b000:  ld_data = {{24{w[7]}}, w[7:0]};
      3'b100:  ld_data = {24'd0, w[7:0]};
      3'b001:  ld_data = {{16{w[15]}}, w[15:0]};
      3'b101:  ld_data = {16'd0, w[15:0]};
      default: ld_data = w;
    endcase
  end

  // strobes arrive lane-0 aligned; legal combos never shift past lane 3
  assign be = r.wstrb << off;
  assign wl = r.wdata << {off, 3'b000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      r       <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        r.write  <= bus.req_write;
        r.addr   <= bus.req_addr;
        r.wdata  <= bus.req_wdata;
        r.wstrb  <= bus.req_wstrb;
        r.funct3 <= bus.req_funct3;
        cnt      <= 4'(WAIT_CYCLES);
      end else if (st == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rdata_q <= (err_c || r.write) ? 32'd0 : ld_data;
        err_q   <= err_c;
      end
    end
  end

  // reset on the access edge wins, so the write sits under the async branch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (access && r.write && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx[AW-1:0]][8*b +: 8] <= wl[8*b +: 8];
      end
    end
  end
endmodule
